// File: rtl/upuart_tx_pkg.sv
// Shared UART definitions: FSM state encodings and serial line levels.
// The receiver imports the same package so both sides agree on framing.
package upuart_tx_pkg;

    typedef enum logic [2:0] {
        UPUART_TX_IDLE   = 3'd0,
        UPUART_TX_START  = 3'd1,
        UPUART_TX_DATA   = 3'd2,
        UPUART_TX_PARITY = 3'd3,
        UPUART_TX_STOP   = 3'd4
    } tx_state_t;

    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;
    localparam logic IDLE_LEVEL  = 1'b1;

endpackage

// File: rtl/upuart_baudgen.sv
// Bit-period timer: loads a period, counts down, and flags the final
// cycle (bit_end) and the cycle before it (near_end).
module upuart_baudgen #(
    parameter int DIVDR_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load,
    input  logic                   run,
    input  logic [DIVDR_WIDTH-1:0] load_val,
    input  logic [DIVDR_WIDTH-1:0] period,
    output logic                   bit_end,
    output logic                   near_end
);

    logic [DIVDR_WIDTH-1:0] cnt;

    // load wins over reload so a new frame can start on the last stop cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val - DIVDR_WIDTH'(1);
        end else if (run) begin
            if (cnt == '0) begin
                cnt <= period - DIVDR_WIDTH'(1);
            end else begin
                cnt <= cnt - DIVDR_WIDTH'(1);
            end
        end
    end

    assign bit_end  = run && (cnt == '0);
    assign near_end = run && (cnt == DIVDR_WIDTH'(1));

endmodule

// File: rtl/upuart_tx.sv
// UART transmit serializer: pops bytes from a FWFT FIFO and sends 8N1 frames.
// Define UPUART_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module upuart_tx
    import upuart_tx_pkg::*;
#(
    parameter int FIFO_WIDTH  = 8,
    parameter int DIVDR_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DIVDR_WIDTH-1:0] divisor,
    input  logic                   fifo_empty,
    input  logic [FIFO_WIDTH-1:0]  fifo_data,
    output logic                   fifo_rd,
    output logic                   txd,
    output logic                   busy
);

    localparam int IDX_W = (FIFO_WIDTH > 1) ? $clog2(FIFO_WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FIFO_WIDTH - 1);

    tx_state_t              state;
    tx_state_t              state_n;
    logic [FIFO_WIDTH-1:0]  shreg;
    logic [IDX_W-1:0]       bit_idx;
    logic [DIVDR_WIDTH-1:0] div_q;
    logic [DIVDR_WIDTH-1:0] div_p;
    logic                   txd_q;
    logic                   txd_n;
    logic                   fifo_rd_q;
    logic                   pop_window;
    logic                   pop_next;
    logic                   load;
    logic                   shift_en;
    logic                   idx_clr;
    logic                   idx_inc;
    logic                   bit_end;
    logic                   near_end;
`ifdef UPUART_TX_PARITY_EN
    logic                   parity_q;
`endif

    assign busy    = (state != UPUART_TX_IDLE);
    assign txd     = txd_q;
    assign fifo_rd = fifo_rd_q;

    upuart_baudgen #(
        .DIVDR_WIDTH(DIVDR_WIDTH)
    ) u_baudgen (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .run     (busy),
        .load_val(div_p),
        .period  (div_q),
        .bit_end (bit_end),
        .near_end(near_end)
    );

    // The pop strobe is registered, so the decision is taken one cycle
    // before the frame boundary; with div_q==1 that is the last pre-stop bit.
    always_comb begin
        pop_window = 1'b0;
        case (state)
            UPUART_TX_IDLE: pop_window = 1'b1;
`ifdef UPUART_TX_PARITY_EN
            UPUART_TX_PARITY: pop_window = (div_q == DIVDR_WIDTH'(1));
`else
            UPUART_TX_DATA: pop_window = (div_q == DIVDR_WIDTH'(1)) && (bit_idx == LAST_IDX);
`endif
            UPUART_TX_STOP: pop_window = near_end;
            default:        pop_window = 1'b0;
        endcase
    end

    assign pop_next = pop_window && (divisor != '0) && !fifo_empty && !fifo_rd_q;

    always_comb begin
        state_n  = state;
        txd_n    = txd_q;
        load     = 1'b0;
        shift_en = 1'b0;
        idx_clr  = 1'b0;
        idx_inc  = 1'b0;
        case (state)
            UPUART_TX_IDLE: begin
                txd_n = IDLE_LEVEL;
                if (fifo_rd_q) begin
                    load    = 1'b1;
                    state_n = UPUART_TX_START;
                    txd_n   = START_LEVEL;
                end
            end
            UPUART_TX_START: begin
                if (bit_end) begin
                    state_n = UPUART_TX_DATA;
                    txd_n   = shreg[0];
                    idx_clr = 1'b1;
                end
            end
            UPUART_TX_DATA: begin
                if (bit_end) begin
                    if (bit_idx == LAST_IDX) begin
`ifdef UPUART_TX_PARITY_EN
                        state_n = UPUART_TX_PARITY;
                        txd_n   = parity_q;
`else
                        state_n = UPUART_TX_STOP;
                        txd_n   = STOP_LEVEL;
`endif
                    end else begin
                        shift_en = 1'b1;
                        idx_inc  = 1'b1;
                        txd_n    = shreg[1];
                    end
                end
            end
`ifdef UPUART_TX_PARITY_EN
            UPUART_TX_PARITY: begin
                if (bit_end) begin
                    state_n = UPUART_TX_STOP;
                    txd_n   = STOP_LEVEL;
                end
            end
`endif
            UPUART_TX_STOP: begin
                if (bit_end) begin
                    if (fifo_rd_q) begin
                        load    = 1'b1;
                        state_n = UPUART_TX_START;
                        txd_n   = START_LEVEL;
                    end else begin
                        state_n = UPUART_TX_IDLE;
                        txd_n   = IDLE_LEVEL;
                    end
                end
            end
            default: begin
                state_n = UPUART_TX_IDLE;
                txd_n   = IDLE_LEVEL;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= UPUART_TX_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // div_p holds the divisor sampled with the pop decision, so a divisor
    // that drops to zero during the strobe cycle cannot load a zero period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            txd_q     <= IDLE_LEVEL;
            fifo_rd_q <= 1'b0;
            shreg     <= '0;
            bit_idx   <= '0;
            div_q     <= '0;
            div_p     <= '0;
        end else begin
            txd_q     <= txd_n;
            fifo_rd_q <= pop_next;
            if (pop_next) begin
                div_p <= divisor;
            end
            if (load) begin
                shreg <= fifo_data;
                div_q <= div_p;
            end else if (shift_en) begin
                shreg <= {1'b0, shreg[FIFO_WIDTH-1:1]};
            end
            if (idx_clr) begin
                bit_idx <= '0;
            end else if (idx_inc) begin
                bit_idx <= bit_idx + IDX_W'(1);
            end
        end
    end

`ifdef UPUART_TX_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parity_q <= 1'b0;
        end else if (load) begin
            parity_q <= ^fifo_data;
        end
    end
`endif

endmodule
